// File: rtl/stream_source_arbiter.sv
// Round-robin arbiter merging the snoop submodule sources onto one registered AXI-Stream port.
// Optional packet counter (pkt_count port) is built only when ARB_PKT_CNT_EN is defined.
module stream_source_arbiter #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned N_SRC      = 5,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_SRC-1:0]            src_valid,
   input  logic [N_SRC-1:0]            src_in_progress,
   input  logic [N_SRC-1:0]            src_last,
   input  logic [N_SRC*DATA_WIDTH-1:0] src_data,
   output logic [N_SRC-1:0]            src_ready,
   output logic [DATA_WIDTH-1:0]       m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast,
   input  logic                        m_axis_tready,
`ifdef ARB_PKT_CNT_EN
   output logic [CNT_WIDTH-1:0]        pkt_count,
`endif
   output logic                        busy
);

   localparam int unsigned IdxW  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int unsigned CandW = IdxW + 1;

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
   logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]   rr_sel, sel;
   logic [CandW-1:0]  cand;
   logic              found, sel_any, slot_free, acc;
   logic              sel_valid, sel_last, sel_in_prog;
   logic [DATA_WIDTH-1:0] sel_data;

   assign slot_free = !m_axis_tvalid || m_axis_tready;
   assign busy      = (state_q == StLocked);

   // Cyclic search starting at rr_ptr; cand never exceeds 2*N_SRC-2 so CandW bits suffice.
   always_comb begin
      found  = 1'b0;
      rr_sel = '0;
      cand   = '0;
      for (int k = 0; k < N_SRC; k++) begin
         cand = {1'b0, rr_ptr_q} + CandW'(k);
         if (cand >= CandW'(N_SRC)) cand = cand - CandW'(N_SRC);
         if (!found && src_valid[cand[IdxW-1:0]]) begin
            found  = 1'b1;
            rr_sel = cand[IdxW-1:0];
         end
      end
   end

   assign sel     = busy ? lock_idx_q : rr_sel;
   assign sel_any = busy || found;

   always_comb begin
      sel_valid   = 1'b0;
      sel_last    = 1'b0;
      sel_in_prog = 1'b0;
      sel_data    = '0;
      src_ready   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (IdxW'(i) == sel) begin
            sel_valid    = src_valid[i];
            sel_last     = src_last[i];
            sel_in_prog  = src_in_progress[i];
            sel_data     = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            src_ready[i] = !reset && slot_free && sel_any;
         end
      end
   end

   assign acc = !reset && slot_free && sel_any && sel_valid;

   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      rr_ptr_d   = rr_ptr_q;
      unique case (state_q)
         StIdle: begin
            if (acc && (!sel_last || sel_in_prog)) begin
               state_d    = StLocked;
               lock_idx_d = sel;
            end
         end
         StLocked: begin
            if (acc && sel_last) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (acc && sel_last) begin
         rr_ptr_d = (sel == IdxW'(N_SRC - 1)) ? '0 : sel + IdxW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         lock_idx_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   // Output register: reload on accept, drain on tready, otherwise hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
      end else if (acc) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tlast  <= sel_last;
         m_axis_tdata  <= sel_data;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

`ifdef ARB_PKT_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_count <= '0;
      end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
         pkt_count <= pkt_count + CNT_WIDTH'(1);
      end
   end
`else
   // CNT_WIDTH only sizes the optional counter.
   logic [CNT_WIDTH-1:0] unused_cnt;
   assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_source_arbiter.sv
// Directed + randomized bench for stream_source_arbiter against a behavioural stream model.
module tb_stream_source_arbiter;

   localparam int N  = 5;
   localparam int DW = 16;
   localparam int CW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    src_valid, src_in_progress, src_last, src_ready;
   logic [DW-1:0]   sd [N];
   logic [N*DW-1:0] src_data;
   logic [DW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid, m_axis_tlast, m_axis_tready, busy;
`ifdef ARB_PKT_CNT_EN
   logic [CW-1:0]   pkt_count;
`endif

   assign src_data = {sd[4], sd[3], sd[2], sd[1], sd[0]};

   always #5 clk = ~clk;

   stream_source_arbiter #(
      .DATA_WIDTH (DW),
      .N_SRC      (N),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .src_valid       (src_valid),
      .src_in_progress (src_in_progress),
      .src_last        (src_last),
      .src_data        (src_data),
      .src_ready       (src_ready),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tready   (m_axis_tready),
`ifdef ARB_PKT_CNT_EN
      .pkt_count       (pkt_count),
`endif
      .busy            (busy)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: stream register contents, burst owner (-1 = none), rotation start.
   bit            model_on = 1'b0;
   bit            mv, ml;
   logic [DW-1:0] md;
   int            owner, rr;
   logic [CW-1:0] pktc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant();
      if (reset) return -1;
      if (mv && !m_axis_tready) return -1;
      if (owner >= 0) return owner;
      for (int k = 0; k < N; k++) begin
         if (src_valid[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   task automatic tick();
      int g;
      logic [N-1:0] er;
      @(negedge clk);
      g  = model_grant();
      er = (g >= 0) ? N'(1 << g) : '0;
      if (model_on) begin
         chk("src_ready", src_ready, er);
         chk("tvalid", m_axis_tvalid, mv);
         chk("tlast", m_axis_tlast, ml);
         chk("tdata", m_axis_tdata, md);
         chk("busy", busy, owner >= 0);
`ifdef ARB_PKT_CNT_EN
         chk("pkt_count", pkt_count, pktc);
`endif
      end
      @(posedge clk);
      if (reset) begin
         model_on = 1'b1;
         mv = 0; ml = 0; md = '0; owner = -1; rr = 0; pktc = '0;
      end else begin
         if (mv && m_axis_tready && ml) pktc = pktc + 1;
         if (g >= 0 && src_valid[g]) begin
            md = sd[g];
            ml = src_last[g];
            mv = 1;
            if (owner < 0) begin
               if (!src_last[g] || src_in_progress[g]) owner = g;
            end else if (src_last[g]) begin
               owner = -1;
            end
            if (src_last[g]) rr = (g + 1) % N;
         end else if (m_axis_tready) begin
            mv = 0;
         end
      end
      #1;
   endtask

   task automatic set_src(input int i, input bit v, input bit l, input bit ip);
      src_valid[i]       = v;
      src_last[i]        = l;
      src_in_progress[i] = ip;
      sd[i]              = {4'(i), 12'($urandom)};
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) set_src(i, 1'b0, 1'b0, 1'b0);
   endtask

   int rr_seq [4] = '{0, 2, 0, 2};

   initial begin
      reset = 1'b1;
      m_axis_tready = 1'b1;
      for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b1, 1'b0);

      // Reset with every source requesting
      repeat (2) begin
         tick();
         chk("rst_tvalid", m_axis_tvalid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_ready", src_ready, 0);
      end
      reset = 1'b0;
      #1 chk("first_ready", src_ready, 5'b00001);
      tick();
      chk("first_src", m_axis_tdata[15:12], 0);

      // Round-robin between sources 0 and 2
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_all();
      set_src(0, 1, 1, 0);
      set_src(2, 1, 1, 0);
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("rr_src", m_axis_tdata[15:12], rr_seq[n]);
         chk("rr_tvalid", m_axis_tvalid, 1);
         set_src(0, 1, 1, 0);
         set_src(2, 1, 1, 0);
      end

      // Burst on source 3 with a 2-cycle gap while source 1 waits
      clear_all();
      set_src(1, 1, 1, 0);
      set_src(3, 1, 0, 1);
      tick();
      chk("burst_b1", m_axis_tdata[15:12], 3);
      chk("burst_busy1", busy, 1);
      set_src(3, 1, 0, 1);
      tick();
      chk("burst_b2", m_axis_tdata[15:12], 3);
      set_src(3, 0, 0, 1);
      repeat (2) begin
         #1 chk("gap_ready1", src_ready[1], 0);
         tick();
         chk("gap_tvalid", m_axis_tvalid, 0);
         chk("gap_busy", busy, 1);
      end
      set_src(3, 1, 0, 1);
      tick();
      chk("burst_b3", m_axis_tdata[15:12], 3);
      chk("burst_busy3", busy, 1);
      set_src(3, 1, 1, 1);
      tick();
      chk("burst_b4", m_axis_tdata[15:12], 3);
      chk("burst_b4_last", m_axis_tlast, 1);
      chk("burst_busy4", busy, 0);
      src_valid[3] = 1'b0;
      tick();
      chk("burst_then1", m_axis_tdata[15:12], 1);

      // Backpressure with 0xDEAD held in the output register
      clear_all();
      src_valid[2] = 1'b1;
      src_last[2]  = 1'b1;
      sd[2]        = 16'hDEAD;
      tick();
      chk("bp_load", m_axis_tdata, 16'hDEAD);
      sd[2] = 16'h2BEE;
      m_axis_tready = 1'b0;
      repeat (3) begin
         #1 chk("bp_ready", src_ready, 0);
         tick();
         chk("bp_hold", m_axis_tdata, 16'hDEAD);
         chk("bp_tvalid", m_axis_tvalid, 1);
      end
      m_axis_tready = 1'b1;
      tick();
      chk("bp_next", m_axis_tdata, 16'h2BEE);

      // Pointer wrap 4 -> 0
      clear_all();
      set_src(3, 1, 1, 0);
      tick();
      chk("wrap_s3", m_axis_tdata[15:12], 3);
      clear_all();
      set_src(0, 1, 1, 0);
      set_src(4, 1, 1, 0);
      tick();
      chk("wrap_s4", m_axis_tdata[15:12], 4);
      set_src(0, 1, 1, 0);
      set_src(4, 1, 1, 0);
      tick();
      chk("wrap_s0", m_axis_tdata[15:12], 0);

`ifdef ARB_PKT_CNT_EN
      clear_all();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_src(0, 1, 1, 0);
      tick();
      clear_all();
      for (int b = 0; b < 4; b++) begin
         set_src(1, 1, b == 3, 0);
         tick();
      end
      clear_all();
      for (int b = 0; b < 2; b++) begin
         set_src(2, 1, b == 1, 0);
         tick();
      end
      clear_all();
      repeat (2) tick();
      chk("pkt_three", pkt_count, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_src(0, 1, 1, 0);
      tick();
      clear_all();
      repeat (2) begin
         set_src(1, 1, 0, 0);
         tick();
      end
      reset = 1'b1;
      tick();
      chk("pkt_rst", pkt_count, 0);
      chk("pkt_rst_tvalid", m_axis_tvalid, 0);
      chk("pkt_rst_tlast", m_axis_tlast, 0);
      reset = 1'b0;
      clear_all();
      tick();
`endif

      // Randomized traffic
      repeat (400) begin
         reset         = ($urandom_range(0, 49) == 0);
         m_axis_tready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            set_src(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0));
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_source_arbiter.md
Name: stream_source_arbiter

Overview:
- Downstream stage of the per-channel snoop submodules (AR, AW, W, R, B).
- Each submodule presents valid/in_progress/last/data and waits on its ready.
- This block grants one source at a time in round-robin order and holds the grant across a multi-beat burst.
- Beats are registered onto a single AXI-Stream master port that feeds the Ethernet packetiser.

Parameters:
- DATA_WIDTH, 128, width of each source data word and of m_axis_tdata
- N_SRC, 5, number of submodule sources; index 0 is highest priority after reset
- CNT_WIDTH, 32, width of pkt_count (optional feature only)

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- src_valid  in  N_SRC  bit i: source i has a beat
- src_in_progress  in  N_SRC  bit i: source i is mid-burst; hold its grant even while src_valid[i]=0
- src_last  in  N_SRC  bit i: current beat of source i ends its packet
- src_data  in  N_SRC*DATA_WIDTH  source i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
- src_ready  out  N_SRC  bit i: source i's beat is accepted this cycle if src_valid[i]=1
- m_axis_tdata  out  DATA_WIDTH  registered stream data
- m_axis_tvalid  out  1  registered stream valid
- m_axis_tlast  out  1  registered stream last
- m_axis_tready  in  1  downstream ready
- busy  out  1  high while a grant is locked (burst open)
- pkt_count  out  CNT_WIDTH  packets emitted; present only with ARB_PKT_CNT_EN

Behaviour:
- Reset values (reset=1 at a clk edge): m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, lock=0, rr_ptr=0, pkt_count=0. While reset=1, src_ready=0.
- Output register is one entry. slot_free = !m_axis_tvalid || m_axis_tready. This is combinational from tready, so there are no bubbles at full throughput.
- Selection, combinational:
  - If lock=1: sel = lock_idx.
  - Else: sel = first i with src_valid[i]=1, searching cyclically from rr_ptr.
  - If none is valid: no selection.
- src_ready[i] = !reset && slot_free && (i == sel). All other bits are 0. src_ready must not depend on src_data or src_last.
- Accept: acc = src_valid[sel] && src_ready[sel].
  - On acc, at the next edge: m_axis_tdata = src_data[sel], m_axis_tlast = src_last[sel], m_axis_tvalid = 1.
  - Latency source-to-stream is 1 cycle.
- If !acc and m_axis_tready=1: m_axis_tvalid clears to 0. If !acc and m_axis_tready=0: the register holds its contents unchanged.
- Lock FSM, states IDLE and LOCKED:
  - IDLE -> LOCKED when acc && !src_last[sel], or when src_in_progress[sel]=1 && acc. lock_idx is captured as sel.
  - LOCKED -> IDLE on acc && src_last[lock_idx].
  - LOCKED with src_valid[lock_idx]=0: stays LOCKED and no other source is granted, regardless of src_in_progress.
  - busy = (state == LOCKED).
- rr_ptr update: on every acc with src_last[sel]=1, rr_ptr = (sel+1) mod N_SRC. The wrap from N_SRC-1 is to 0. rr_ptr is unchanged otherwise.
- Single-beat sources (last=valid, in_progress=0) never enter LOCKED, so each beat rotates priority.
- Simultaneous valids: exactly one is granted per cycle; the others see src_ready=0 and must hold.
- Backpressure: while m_axis_tready=0 and m_axis_tvalid=1, all src_ready=0 and the output is stable (AXI-Stream rule).
- Reset mid-burst: state returns to IDLE and the output register is emptied. The partial packet is dropped; no tlast is generated.

Optional Feature:
- Macro: ARB_PKT_CNT_EN.
- Defined:
  - pkt_count increments by 1 at each edge where m_axis_tvalid && m_axis_tready && m_axis_tlast.
  - It wraps from 2^CNT_WIDTH-1 to 0 and resets to 0.
- Undefined: the pkt_count port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset 2 cycles with all src_valid=5'b11111 -> src_ready=0, m_axis_tvalid=0, busy=0 throughout. The first grant after release is source 0.
- Round-robin: src_valid=5'b00101 held, all last=1, tready=1 -> emitted sources in order 0,2,0,2. One beat per cycle with tvalid continuously high after the first cycle.
- Burst lock: source 3 sends 4 beats (last on 4th) with a 2-cycle valid gap after beat 2, while source 1 is valid throughout -> stream shows 3,3,3,3 then 1. busy=1 from after beat 1 until after beat 4. src_ready[1]=0 during the gap.
- Backpressure: tready=0 for 3 cycles with a beat 0xDEAD held in the register -> tdata stays 0xDEAD and tvalid stays 1, all src_ready=0. On tready=1, the next beat appears 1 cycle later.
- Wrap: rr_ptr=4 after source 3 completes, src_valid=5'b10001 -> source 4 is granted, then source 0.
- ARB_PKT_CNT_EN: send 3 packets (lengths 1, 4, 2 beats) -> pkt_count=3. A reset mid-2nd-packet leaves pkt_count=0 and no tlast emitted.
